fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC pipeline; directly upstream of the IF/ID buffer.
- Owns the 32-bit word-addressed PC.
- Boots by loading the reset vector from instruction memory.
- Drives instruction memory (asynchronous read), then presents instruction/pc/nextPC/iamBubble to the IF/ID buffer each cycle.
- Handles stall, branch redirect and HALT.

Parameters:
- RESET_VEC_ADDR, 32'd0: word address of reset-vector high half; low half at +1.
- INT_VEC_ADDR, 32'd2: word address of interrupt-vector high half; low half at +1. Used only with INT_EN.
- HALT_OPCODE, 5'b00001: value of instruction[15:11] that identifies HALT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hazard-unit stall; hold PC.
- branchTaken  in  1  redirect request from EX.
- branchTarget  in  32  redirect word address.
- memAddr  out  32  instruction-memory word address.
- memData  in  16  instruction-memory read data, valid same cycle as memAddr.
- instruction  out  16  fetched word to IF/ID.
- pc  out  32  address of instruction.
- nextPC  out  32  pc+1, to IF/ID.
- iamBubble  out  1  1 = instruction is not a real instruction.
- intr  in  1  interrupt request, level. INT_EN only.
- intPc  out  32  resume address for the interrupt handler. INT_EN only.

Behaviour:
- Reset is asynchronous and active-high on rst; single clock clk.
- Internal state: pcReg[31:0], vecHi[15:0], state in {VEC_HI, VEC_LO, RUN, HALTED} (+IV_HI, IV_LO with INT_EN).
- Reset values: state=VEC_HI, pcReg=0, vecHi=0.
- Outputs are combinational from state/pcReg/memData. No extra latency; the IF/ID buffer provides the register.
- VEC_HI:
  - memAddr=RESET_VEC_ADDR; instruction=0, pc=0, nextPC=0, iamBubble=1.
  - Next edge: vecHi<=memData; go to VEC_LO.
- VEC_LO:
  - memAddr=RESET_VEC_ADDR+1; instruction=0, pc=0, nextPC=0, iamBubble=1.
  - Next edge: pcReg<={vecHi,memData}; go to RUN.
- RUN:
  - memAddr=pcReg; instruction=memData; pc=pcReg; nextPC=pcReg+1 (32-bit wrap, FFFF_FFFF+1=0); iamBubble=0.
- RUN edge priority (highest first):
  1. branchTaken: pcReg<=branchTarget. Applies even while stall=1.
  2. stall: pcReg held; same word re-presented next cycle.
  3. memData[15:11]==HALT_OPCODE: pcReg held; go to HALTED. The HALT word itself is emitted this cycle with iamBubble=0.
  4. Otherwise pcReg<=pcReg+1.
- HALTED:
  - memAddr=pcReg; instruction=0, pc=pcReg, nextPC=pcReg+1, iamBubble=1.
  - branchTaken: pcReg<=branchTarget; go to RUN. This covers an older branch resolving after HALT was fetched.
  - Otherwise remain in HALTED until rst.
- branchTaken and stall are ignored in VEC_HI/VEC_LO.
- rst asserted mid-operation, in any state, returns to VEC_HI immediately (asynchronous). Outputs take VEC_HI values in the same cycle.
- Consecutive branches on back-to-back cycles: each is honoured; the last one wins.

Optional Feature:
- Macro: INT_EN.
- Defined:
  - intr is sampled in RUN or HALTED when branchTaken=0 and stall=0. Sampling takes priority over HALT detect and increment.
  - On sample: intPc register <= pcReg in RUN (the instruction at pcReg is not issued; iamBubble=1 that cycle), or pcReg+1 in HALTED. Go to IV_HI.
  - IV_HI/IV_LO mirror VEC_HI/VEC_LO using INT_VEC_ADDR, then enter RUN.
  - intPc resets to 0 and holds its value until the next interrupt.
- Undefined: intr and intPc ports absent; IV states absent; behaviour otherwise identical.

Test Plan:
- Boot: mem[0]=16'h0000, mem[1]=16'h0010, rst pulse → 2 cycles of iamBubble=1, then pc=0x10, nextPC=0x11, iamBubble=0.
- Sequential run: mem[0x10..0x12]=A,B,C, no stall → instruction A,B,C on consecutive cycles with pc 0x10,0x11,0x12.
- Stall: stall=1 for 3 cycles at pc=0x11 → instruction B with pc=0x11 held for 3 cycles, then 0x12.
- Branch during stall: stall=1, branchTaken=1, branchTarget=0x40 at pc=0x12 → next cycle pc=0x40.
- HALT: mem[0x41]=16'h0800 → pc=0x41 emitted with iamBubble=0, then iamBubble=1, instruction=0, pc frozen at 0x41; rst returns to VEC_HI asynchronously.
- INT_EN: mem[2]=0, mem[3]=0x80, intr=1 at pc=0x20 → intPc=0x20, 2 bubble cycles, then pc=0x80; in HALTED at 0x41, intPc=0x42.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: boots from the reset vector, then walks the word-addressed PC.
// Optional interrupt entry is built only when the INT_EN macro is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
  parameter logic [31:0] INT_VEC_ADDR   = 32'd2,
  parameter logic [4:0]  HALT_OPCODE    = 5'b00001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic [31:0] memAddr,
  input  logic [15:0] memData,
  output logic [15:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] nextPC,
  output logic        iamBubble,
`ifdef INT_EN
  input  logic        intr,
  output logic [31:0] intPc,
`endif
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_VEC_HI = 3'd0,
    S_VEC_LO = 3'd1,
    S_RUN    = 3'd2,
    S_HALTED = 3'd3
`ifdef INT_EN
    ,
    S_IV_HI  = 3'd4,
    S_IV_LO  = 3'd5
`endif
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [15:0] r_vec_hi;
  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [15:0] w_vec_hi_nxt;
  logic [31:0] w_pc_inc;
  logic        w_is_halt;
`ifdef INT_EN
  logic [31:0] r_int_pc;
  logic [31:0] w_int_pc_nxt;
  logic        w_int_take;
`endif

  assign w_pc_inc    = r_pc + 32'd1;
  assign w_is_halt   = (memData[15:11] == HALT_OPCODE);
  assign o_dbg_state = r_state;

`ifdef INT_EN
  // An interrupt is only taken on a cycle that neither redirects nor stalls.
  assign w_int_take = intr && !branchTaken && !stall &&
                      ((r_state == S_RUN) || (r_state == S_HALTED));
  assign intPc      = r_int_pc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_VEC_HI;
      r_pc     <= 32'd0;
      r_vec_hi <= 16'd0;
`ifdef INT_EN
      r_int_pc <= 32'd0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_vec_hi <= w_vec_hi_nxt;
`ifdef INT_EN
      r_int_pc <= w_int_pc_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_vec_hi_nxt = r_vec_hi;
`ifdef INT_EN
    w_int_pc_nxt = r_int_pc;
`endif
    unique case (r_state)
      S_VEC_HI: begin
        w_vec_hi_nxt = memData;
        w_state_nxt  = S_VEC_LO;
      end
      S_VEC_LO: begin
        w_pc_nxt    = {r_vec_hi, memData};
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (branchTaken) begin
          w_pc_nxt = branchTarget;
        end else if (stall) begin
          w_pc_nxt = r_pc;
`ifdef INT_EN
        end else if (w_int_take) begin
          w_int_pc_nxt = r_pc;
          w_state_nxt  = S_IV_HI;
`endif
        end else if (w_is_halt) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      S_HALTED: begin
        // A branch older than the HALT may still resolve and pull us back out.
        if (branchTaken) begin
          w_pc_nxt    = branchTarget;
          w_state_nxt = S_RUN;
`ifdef INT_EN
        end else if (w_int_take) begin
          w_int_pc_nxt = w_pc_inc;
          w_state_nxt  = S_IV_HI;
`endif
        end
      end
`ifdef INT_EN
      S_IV_HI: begin
        w_vec_hi_nxt = memData;
        w_state_nxt  = S_IV_LO;
      end
      S_IV_LO: begin
        w_pc_nxt    = {r_vec_hi, memData};
        w_state_nxt = S_RUN;
      end
`endif
      default: begin
        w_state_nxt = S_VEC_HI;
      end
    endcase
  end

  // iamBubble acts as the valid flag toward IF/ID; there is no backpressure path.
  always_comb begin
    memAddr     = r_pc;
    instruction = 16'd0;
    pc          = 32'd0;
    nextPC      = 32'd0;
    iamBubble   = 1'b1;
    unique case (r_state)
      S_VEC_HI: memAddr = RESET_VEC_ADDR;
      S_VEC_LO: memAddr = RESET_VEC_ADDR + 32'd1;
      S_RUN: begin
        instruction = memData;
        pc          = r_pc;
        nextPC      = w_pc_inc;
`ifdef INT_EN
        iamBubble   = w_int_take;
`else
        iamBubble   = 1'b0;
`endif
      end
      S_HALTED: begin
        pc     = r_pc;
        nextPC = w_pc_inc;
      end
`ifdef INT_EN
      S_IV_HI: memAddr = INT_VEC_ADDR;
      S_IV_LO: memAddr = INT_VEC_ADDR + 32'd1;
`endif
      default: memAddr = RESET_VEC_ADDR;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, sequential fetch, stall, branch, HALT, wrap, async reset.
// Interrupt scenarios are compiled in only when INT_EN is defined.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] memAddr;
  logic [15:0] memData;
  logic [15:0] instruction;
  logic [31:0] pc;
  logic [31:0] nextPC;
  logic        iamBubble;
  logic [2:0]  o_dbg_state;
`ifdef INT_EN
  logic        intr;
  logic [31:0] intPc;
`endif

  logic [15:0]  mem [0:255];
  logic [112:0] obs;
  integer       checks;
  integer       failures;

  localparam logic [15:0] INS_A = 16'h1234;
  localparam logic [15:0] INS_B = 16'h2345;
  localparam logic [15:0] INS_C = 16'h3456;
  localparam logic [15:0] HALT_W = 16'h0800;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .memAddr      (memAddr),
    .memData      (memData),
    .instruction  (instruction),
    .pc           (pc),
    .nextPC       (nextPC),
    .iamBubble    (iamBubble),
`ifdef INT_EN
    .intr         (intr),
    .intPc        (intPc),
`endif
    .o_dbg_state  (o_dbg_state)
  );

  // Asynchronous instruction memory, 256 words aliased over the address space.
  assign memData = mem[memAddr[7:0]];
  assign obs     = {memAddr, instruction, pc, nextPC, iamBubble};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t);
    stall        = s;
    branchTaken  = b;
    branchTarget = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    step();
    step();
    checks++;
    if (obs !== {32'd0, 16'd0, 32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, {32'd0, 16'd0, 32'd0, 32'd0, 1'b1});
    end
    rst = 1'b0;
  endtask

  task automatic test_boot();
    // Stall and branch must be ignored while reading the vector.
    drive(1'b1, 1'b1, 32'h99);
    checks++;
    if (obs !== {32'd0, 16'd0, 32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL boot_vec_hi got=%h exp=%h", obs, {32'd0, 16'd0, 32'd0, 32'd0, 1'b1});
    end
    step();
    checks++;
    if (obs !== {32'd1, 16'd0, 32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL boot_vec_lo got=%h exp=%h", obs, {32'd1, 16'd0, 32'd0, 32'd0, 1'b1});
    end
    step();
    drive(1'b0, 1'b0, 32'd0);
    checks++;
    if (obs !== {32'h10, INS_A, 32'h10, 32'h11, 1'b0}) begin
      failures++;
      $display("FAIL boot_run got=%h exp=%h", obs, {32'h10, INS_A, 32'h10, 32'h11, 1'b0});
    end
  endtask

  task automatic test_sequential();
    step();
    checks++;
    if (obs !== {32'h11, INS_B, 32'h11, 32'h12, 1'b0}) begin
      failures++;
      $display("FAIL seq_b got=%h exp=%h", obs, {32'h11, INS_B, 32'h11, 32'h12, 1'b0});
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== {32'h11, INS_B, 32'h11, 32'h12, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs, {32'h11, INS_B, 32'h11, 32'h12, 1'b0});
      end
    end
    drive(1'b0, 1'b0, 32'd0);
    step();
    checks++;
    if (obs !== {32'h12, INS_C, 32'h12, 32'h13, 1'b0}) begin
      failures++;
      $display("FAIL stall_release got=%h exp=%h", obs, {32'h12, INS_C, 32'h12, 32'h13, 1'b0});
    end
  endtask

  task automatic test_branch_during_stall();
    drive(1'b1, 1'b1, 32'h40);
    step();
    drive(1'b0, 1'b0, 32'd0);
    checks++;
    if (obs !== {32'h40, 16'h4000, 32'h40, 32'h41, 1'b0}) begin
      failures++;
      $display("FAIL branch_stall got=%h exp=%h", obs, {32'h40, 16'h4000, 32'h40, 32'h41, 1'b0});
    end
  endtask

  task automatic test_halt();
    step();
    checks++;
    if (obs !== {32'h41, HALT_W, 32'h41, 32'h42, 1'b0}) begin
      failures++;
      $display("FAIL halt_emit got=%h exp=%h", obs, {32'h41, HALT_W, 32'h41, 32'h42, 1'b0});
    end
    step();
    checks++;
    if (obs !== {32'h41, 16'd0, 32'h41, 32'h42, 1'b1}) begin
      failures++;
      $display("FAIL halt_frozen got=%h exp=%h", obs, {32'h41, 16'd0, 32'h41, 32'h42, 1'b1});
    end
    drive(1'b1, 1'b0, 32'd0);
    step();
    drive(1'b0, 1'b0, 32'd0);
    checks++;
    if (obs !== {32'h41, 16'd0, 32'h41, 32'h42, 1'b1}) begin
      failures++;
      $display("FAIL halt_stays got=%h exp=%h", obs, {32'h41, 16'd0, 32'h41, 32'h42, 1'b1});
    end
  endtask

  task automatic test_halt_branch_wrap();
    drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 1'b0, 32'd0);
    checks++;
    if (obs !== {32'hFFFF_FFFF, 16'h5555, 32'hFFFF_FFFF, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL halt_exit_wrap got=%h exp=%h", obs, {32'hFFFF_FFFF, 16'h5555, 32'hFFFF_FFFF, 32'd0, 1'b0});
    end
    step();
    checks++;
    if (obs !== {32'd0, 16'd0, 32'd0, 32'd1, 1'b0}) begin
      failures++;
      $display("FAIL wrap_to_zero got=%h exp=%h", obs, {32'd0, 16'd0, 32'd0, 32'd1, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 32'h30);
    step();
    checks++;
    if (obs !== {32'h30, 16'h6000, 32'h30, 32'h31, 1'b0}) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=%h", obs, {32'h30, 16'h6000, 32'h30, 32'h31, 1'b0});
    end
    drive(1'b0, 1'b1, 32'h50);
    step();
    drive(1'b0, 1'b0, 32'd0);
    checks++;
    if (obs !== {32'h50, 16'h7000, 32'h50, 32'h51, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second got=%h exp=%h", obs, {32'h50, 16'h7000, 32'h50, 32'h51, 1'b0});
    end
    step();
    checks++;
    if (obs !== {32'h51, 16'h7001, 32'h51, 32'h52, 1'b0}) begin
      failures++;
      $display("FAIL b2b_follow got=%h exp=%h", obs, {32'h51, 16'h7001, 32'h51, 32'h52, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    // Reach HALTED at 0x41, then pulse rst away from any clock edge.
    drive(1'b0, 1'b1, 32'h41);
    step();
    drive(1'b0, 1'b0, 32'd0);
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== {32'd0, 16'd0, 32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs, {32'd0, 16'd0, 32'd0, 32'd0, 1'b1});
    end
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (obs !== {32'h10, INS_A, 32'h10, 32'h11, 1'b0}) begin
      failures++;
      $display("FAIL reboot_run got=%h exp=%h", obs, {32'h10, INS_A, 32'h10, 32'h11, 1'b0});
    end
  endtask

`ifdef INT_EN
  task automatic test_interrupt();
    drive(1'b0, 1'b1, 32'h20);
    step();
    drive(1'b0, 1'b0, 32'd0);
    intr = 1'b1;
    #1;
    checks++;
    if (iamBubble !== 1'b1) begin
      failures++;
      $display("FAIL int_bubble got=%b exp=1", iamBubble);
    end
    step();
    intr = 1'b0;
    checks++;
    if ({intPc, memAddr, iamBubble} !== {32'h20, 32'd2, 1'b1}) begin
      failures++;
      $display("FAIL int_iv_hi got=%h exp=%h", {intPc, memAddr, iamBubble}, {32'h20, 32'd2, 1'b1});
    end
    step();
    step();
    checks++;
    if ({pc, iamBubble} !== {32'h80, 1'b0}) begin
      failures++;
      $display("FAIL int_handler got=%h exp=%h", {pc, iamBubble}, {32'h80, 1'b0});
    end
    drive(1'b0, 1'b1, 32'h41);
    step();
    drive(1'b0, 1'b0, 32'd0);
    step();
    intr = 1'b1;
    step();
    intr = 1'b0;
    checks++;
    if (intPc !== 32'h42) begin
      failures++;
      $display("FAIL int_halted_pc got=%h exp=%h", intPc, 32'h42);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h0000;
    mem[8'h01] = 16'h0010;
    mem[8'h02] = 16'h0000;
    mem[8'h03] = 16'h0080;
    mem[8'h10] = INS_A;
    mem[8'h11] = INS_B;
    mem[8'h12] = INS_C;
    mem[8'h30] = 16'h6000;
    mem[8'h40] = 16'h4000;
    mem[8'h41] = HALT_W;
    mem[8'h50] = 16'h7000;
    mem[8'h51] = 16'h7001;
    mem[8'hFF] = 16'h5555;
`ifdef INT_EN
    intr = 1'b0;
`endif
    test_reset();
    test_boot();
    test_sequential();
    test_stall();
    test_branch_during_stall();
    test_halt();
    test_halt_branch_wrap();
    test_back_to_back();
    test_async_reset();
`ifdef INT_EN
    test_interrupt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
